// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute and write back
// an 8-bit instruction against an external 4-entry register file.
module instr_sequencer #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instrValid,
    input  logic [7:0] instr,
    output logic       instrReady,
    output logic [7:0] pc,
    output logic [1:0] readReg1,
    output logic [1:0] readReg2,
    input  logic [7:0] readData1,
    input  logic [7:0] readData2,
    output logic [1:0] writeReg,
    output logic [7:0] writeData,
    output logic       sigRegWrite
);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] result_q, result_d;
    logic       ready_q, ready_d;
    logic       wr_q, wr_d;

    logic [1:0] op;
    logic [7:0] imm_ext;
    logic [7:0] jmp_off;

    assign op      = ir_q[7:6];
    assign imm_ext = {{6{ir_q[1]}}, ir_q[1:0]};
    assign jmp_off = {{2{ir_q[5]}}, ir_q[5:0]};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        result_d = result_q;
        unique case (state_q)
            FETCH: begin
                if (instrValid) begin
                    ir_d    = instr;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                unique case (op)
                    2'b00: result_d = readData1 + readData2;
                    2'b01: result_d = readData1 + imm_ext;
                    2'b10: result_d = readData1 - readData2;
                    2'b11: result_d = result_q;
                endcase
                state_d = WB;
            end
            WB: begin
                if (op == 2'b11) pc_d = pc_q + 8'd1 + jmp_off;
                else             pc_d = pc_q + 8'd1;
                state_d = FETCH;
            end
        endcase
        // Handshake and write strobe are registered off the next state.
        ready_d = (state_d == FETCH);
        wr_d    = (state_d == WB) && (op != 2'b11);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= PC_RESET;
            ir_q     <= 8'h00;
            result_q <= 8'h00;
            ready_q  <= 1'b1;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            wr_q     <= wr_d;
        end
    end

    assign instrReady  = ready_q;
    assign pc          = pc_q;
    assign readReg1    = ir_q[5:4];
    assign readReg2    = ir_q[3:2];
    assign writeReg    = (op == 2'b01) ? ir_q[3:2] : ir_q[1:0];
    assign writeData   = result_q;
    assign sigRegWrite = wr_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a behavioural 4x8 register file.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instrValid;
    logic [7:0] instr;
    logic       instrReady;
    logic [7:0] pc;
    logic [1:0] readReg1, readReg2, writeReg;
    logic [7:0] readData1, readData2, writeData;
    logic       sigRegWrite;

    logic [7:0] regs [4];
    int         pulses = 0;
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.PC_RESET(8'h00)) dut (
        .clk(clk), .reset(reset),
        .instrValid(instrValid), .instr(instr),
        .instrReady(instrReady), .pc(pc),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(readData1), .readData2(readData2),
        .writeReg(writeReg), .writeData(writeData),
        .sigRegWrite(sigRegWrite)
    );

    assign readData1 = regs[readReg1];
    assign readData2 = regs[readReg2];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else if (sigRegWrite) begin
            regs[writeReg] <= writeData;
        end
        if (sigRegWrite) pulses <= pulses + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] ins;
        logic       we;
        logic [1:0] wreg;
        logic [7:0] wdata;
        logic [7:0] pc_after;
    } vec_t;

    task automatic run(input vec_t v);
        @(negedge clk);
        chk("fetch_ready", instrReady, 1);
        instrValid = 1'b1;
        instr = v.ins;
        @(posedge clk);
        @(negedge clk);
        instrValid = 1'b0;
        instr = 8'hFF;
        chk("decode_ready", instrReady, 0);
        chk("decode_we", sigRegWrite, 0);
        chk("decode_rr1", readReg1, v.ins[5:4]);
        chk("decode_rr2", readReg2, v.ins[3:2]);
        @(negedge clk);
        chk("exec_we", sigRegWrite, 0);
        chk("exec_ready", instrReady, 0);
        @(negedge clk);
        chk("wb_we", sigRegWrite, v.we);
        chk("wb_ready", instrReady, 0);
        if (v.we) begin
            chk("wb_wreg", writeReg, v.wreg);
            chk("wb_wdata", writeData, v.wdata);
        end
        @(negedge clk);
        chk("next_pc", pc, v.pc_after);
        chk("next_ready", instrReady, 1);
        chk("next_we", sigRegWrite, 0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t tbl [10];
    int   p0;
    logic [7:0] pc_hold;

    initial begin
        tbl[0] = '{8'h45, 1'b1, 2'd1, 8'h01, 8'h01};
        tbl[1] = '{8'h16, 1'b1, 2'd2, 8'h02, 8'h02};
        tbl[2] = '{8'h87, 1'b1, 2'd3, 8'hFF, 8'h03};
        tbl[3] = '{8'h4B, 1'b1, 2'd2, 8'hFF, 8'h04};
        tbl[4] = '{8'h2E, 1'b1, 2'd2, 8'hFE, 8'h05};
        tbl[5] = '{8'hFE, 1'b0, 2'd0, 8'h00, 8'h04};
        tbl[6] = '{8'h9D, 1'b1, 2'd1, 8'h02, 8'h05};
        tbl[7] = '{8'hC1, 1'b0, 2'd0, 8'h00, 8'h07};
        tbl[8] = '{8'h66, 1'b1, 2'd1, 8'hFC, 8'h08};
        tbl[9] = '{8'h15, 1'b1, 2'd1, 8'hF8, 8'h09};

        reset = 1'b1;
        instrValid = 1'b0;
        instr = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 8'h00);
        chk("rst_ready", instrReady, 1);
        chk("rst_we", sigRegWrite, 0);
        chk("rst_wreg", writeReg, 0);
        chk("rst_rr1", readReg1, 0);
        chk("rst_rr2", readReg2, 0);
        chk("rst_wdata", writeData, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run(tbl[i]);

        // Stall in FETCH, then accept
        instr = 8'h87;
        pc_hold = pc;
        p0 = pulses;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ready", instrReady, 1);
            chk("stall_pc", pc, pc_hold);
            chk("stall_we", sigRegWrite, 0);
            chk("stall_rr1", readReg1, 2'd1);
        end
        chk("stall_pulses", pulses, p0);
        run('{8'h45, 1'b1, 2'd1, 8'h01, 8'h0A});

        // Reset during EXEC aborts
        @(negedge clk);
        instrValid = 1'b1;
        instr = 8'h45;
        @(posedge clk);
        @(negedge clk);
        instrValid = 1'b0;
        @(negedge clk);
        p0 = pulses;
        reset = 1'b1;
        #1;
        chk("abx_pc", pc, 8'h00);
        chk("abx_ready", instrReady, 1);
        chk("abx_we", sigRegWrite, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abx_pulses", pulses, p0);
        chk("abx_ready2", instrReady, 1);
        chk("abx_pc2", pc, 8'h00);

        // Reset during WB suppresses the write
        @(negedge clk);
        instrValid = 1'b1;
        instr = 8'h45;
        @(posedge clk);
        @(negedge clk);
        instrValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abw_we_pre", sigRegWrite, 1);
        p0 = pulses;
        reset = 1'b1;
        #1;
        chk("abw_we", sigRegWrite, 0);
        chk("abw_pc", pc, 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abw_pulses", pulses, p0);

        // pc wrap FF -> 00
        run('{8'hFE, 1'b0, 2'd0, 8'h00, 8'hFF});
        run('{8'h45, 1'b1, 2'd1, 8'h01, 8'h00});

        // Back-to-back: one write every 4 cycles
        @(negedge clk);
        instrValid = 1'b1;
        instr = 8'h45;
        p0 = pulses;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("b2b_we", sigRegWrite, (k % 4 == 3));
        end
        instrValid = 1'b0;
        chk("b2b_pulses", pulses - p0, 3);
        chk("b2b_pc", pc, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
